// File: rtl/stack_ctrl.sv
// stack_ctrl: downward-growing hardware stack pointer controller.
// Issues one or two stack memory word accesses per accepted push/pop,
// checks capacity for the whole operation up front, and keeps sticky
// overflow/underflow flags.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   op_valid     operation request; push_pop (1 push / 0 pop), op_two (two words)
//   op_ready     request accepted when op_valid && op_ready (combinational)
//   sp_load      load sp from sp_load_val (IDLE only, blocks acceptance)
//   exc_clr      clear sticky overflow/underflow
//   mem_en       stack memory access this cycle (combinational)
//   mem_addr     word address of the access (combinational)
//   mem_word     word index within the operation (combinational)
//   busy         second word of a two-word operation in progress
//   sp           stack pointer, first empty location
//   level        words currently on the stack
//   overflow     sticky rejected-push flag
//   underflow    sticky rejected-pop flag
module stack_ctrl #(
  parameter int unsigned          ADDR_W  = 32,
  parameter logic [ADDR_W-1:0]    SP_INIT = ADDR_W'(32'h000F_FFFF),
  parameter int unsigned          DEPTH   = 1024,
  localparam int unsigned         LVL_W   = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  input  logic              push_pop,
  input  logic              op_two,
  output logic              op_ready,
  input  logic              sp_load,
  input  logic [ADDR_W-1:0] sp_load_val,
  input  logic              exc_clr,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_word,
  output logic              busy,
  output logic [ADDR_W-1:0] sp,
  output logic [LVL_W-1:0]  level,
  output logic              overflow,
  output logic              underflow
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } stateT;

  stateT             stateQ, stateD;
  logic [ADDR_W-1:0] spQ, spD;
  logic              secondPushQ, secondPushD;
  logic              overflowQ, overflowD;
  logic              underflowQ, underflowD;

  logic [LVL_W:0]    levelExt;
  logic [LVL_W:0]    nWords;
  logic              pushOk, popOk, opOk;

  // Occupancy is derived from sp; truncation handles out-of-range sp loads.
  assign level     = LVL_W'(SP_INIT - spQ);
  assign sp        = spQ;
  assign overflow  = overflowQ;
  assign underflow = underflowQ;

  // Whole-operation capacity check, one bit wider so level + 2 cannot wrap.
  assign levelExt = {1'b0, level};
  assign nWords   = op_two ? (LVL_W+1)'(2) : (LVL_W+1)'(1);
  assign pushOk   = (levelExt + nWords) <= (LVL_W+1)'(DEPTH);
  assign popOk    = levelExt >= nWords;
  assign opOk     = push_pop ? pushOk : popOk;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stateQ      <= IDLE;
      spQ         <= SP_INIT;
      secondPushQ <= 1'b0;
      overflowQ   <= 1'b0;
      underflowQ  <= 1'b0;
    end else begin
      stateQ      <= stateD;
      spQ         <= spD;
      secondPushQ <= secondPushD;
      overflowQ   <= overflowD;
      underflowQ  <= underflowD;
    end
  end

  // Next state, sp update, flag update and memory access outputs.
  always_comb begin
    stateD      = stateQ;
    spD         = spQ;
    secondPushD = secondPushQ;
    overflowD   = overflowQ;
    underflowD  = underflowQ;
    op_ready    = 1'b0;
    mem_en      = 1'b0;
    mem_word    = 1'b0;
    busy        = 1'b0;
    mem_addr    = spQ;

    if (exc_clr) begin
      overflowD  = 1'b0;
      underflowD = 1'b0;
    end

    // While reset is low nothing is issued; the registers reload at the edge.
    if (reset) begin
      case (stateQ)
        IDLE: begin
          op_ready = !sp_load;
          if (sp_load) begin
            spD = sp_load_val;
          end else if (op_valid) begin
            if (opOk) begin
              mem_en = 1'b1;
              if (push_pop) begin
                mem_addr = spQ;
                spD      = spQ - ADDR_W'(1);
              end else begin
                mem_addr = spQ + ADDR_W'(1);
                spD      = spQ + ADDR_W'(1);
              end
              if (op_two) begin
                stateD      = SECOND;
                secondPushD = push_pop;
              end
            end else if (push_pop) begin
              overflowD = 1'b1;
            end else begin
              underflowD = 1'b1;
            end
          end
        end
        SECOND: begin
          // Second word uses the sp already moved by the first word.
          mem_en   = 1'b1;
          mem_word = 1'b1;
          busy     = 1'b1;
          stateD   = IDLE;
          if (secondPushQ) begin
            mem_addr = spQ;
            spD      = spQ - ADDR_W'(1);
          end else begin
            mem_addr = spQ + ADDR_W'(1);
            spD      = spQ + ADDR_W'(1);
          end
        end
        default: stateD = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed self-checking bench for stack_ctrl: a default-parameter instance
// plus a DEPTH=4 instance sharing the same stimulus for capacity boundaries.
module tb_stack_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        op_valid = 1'b0;
  logic        push_pop = 1'b0;
  logic        op_two = 1'b0;
  logic        sp_load = 1'b0;
  logic [31:0] sp_load_val = 32'h0;
  logic        exc_clr = 1'b0;

  logic        op_ready, mem_en, mem_word, busy, overflow, underflow;
  logic [31:0] mem_addr, sp;
  logic [10:0] level;

  logic        sOpReady, sMemEn, sMemWord, sBusy, sOverflow, sUnderflow;
  logic [31:0] sMemAddr, sSp;
  logic [2:0]  sLevel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stack_ctrl dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .push_pop(push_pop),
    .op_two(op_two), .op_ready(op_ready), .sp_load(sp_load),
    .sp_load_val(sp_load_val), .exc_clr(exc_clr), .mem_en(mem_en),
    .mem_addr(mem_addr), .mem_word(mem_word), .busy(busy), .sp(sp),
    .level(level), .overflow(overflow), .underflow(underflow)
  );

  stack_ctrl #(.DEPTH(4)) dutSmall (
    .clk(clk), .reset(reset), .op_valid(op_valid), .push_pop(push_pop),
    .op_two(op_two), .op_ready(sOpReady), .sp_load(sp_load),
    .sp_load_val(sp_load_val), .exc_clr(exc_clr), .mem_en(sMemEn),
    .mem_addr(sMemAddr), .mem_word(sMemWord), .busy(sBusy), .sp(sSp),
    .level(sLevel), .overflow(sOverflow), .underflow(sUnderflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b0; op_valid = 1'b0; push_pop = 1'b0; op_two = 1'b0;
    sp_load = 1'b0; sp_load_val = 32'h0; exc_clr = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; op_valid = 1'b1; push_pop = 1'b1;
    #1;
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en got %0b want 0", mem_en); end
    checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL rst_op_ready got %0b want 0", op_ready); end
    tick();
    checks++; if (sp !== 32'h000F_FFFF) begin errors++; $display("FAIL rst_sp got %h want 000fffff", sp); end
    checks++; if (level !== 11'd0) begin errors++; $display("FAIL rst_level got %0d want 0", level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got %0b want 0", overflow); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL rst_underflow got %0b want 0", underflow); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b want 0", busy); end
    checks++; if (sSp !== 32'h000F_FFFF) begin errors++; $display("FAIL rst_small_sp got %h want 000fffff", sSp); end
    op_valid = 1'b0; push_pop = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_push_single();
    doReset();
    op_valid = 1'b1; push_pop = 1'b1; op_two = 1'b0;
    #1;
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL push1_ready got %0b want 1", op_ready); end
    checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL push1_en got %0b want 1", mem_en); end
    checks++; if (mem_addr !== 32'h000F_FFFF) begin errors++; $display("FAIL push1_addr got %h want 000fffff", mem_addr); end
    checks++; if (mem_word !== 1'b0) begin errors++; $display("FAIL push1_word got %0b want 0", mem_word); end
    tick();
    op_valid = 1'b0;
    #1;
    checks++; if (sp !== 32'h000F_FFFE) begin errors++; $display("FAIL push1_sp got %h want 000ffffe", sp); end
    checks++; if (level !== 11'd1) begin errors++; $display("FAIL push1_level got %0d want 1", level); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL idle_en got %0b want 0", mem_en); end
    checks++; if (mem_addr !== 32'h000F_FFFE) begin errors++; $display("FAIL idle_addr got %h want 000ffffe", mem_addr); end
    op_valid = 1'b1; push_pop = 1'b0;
    #1;
    checks++; if (mem_addr !== 32'h000F_FFFF) begin errors++; $display("FAIL pop1_addr got %h want 000fffff", mem_addr); end
    checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL pop1_en got %0b want 1", mem_en); end
    tick();
    op_valid = 1'b0;
    #1;
    checks++; if (sp !== 32'h000F_FFFF) begin errors++; $display("FAIL pop1_sp got %h want 000fffff", sp); end
    checks++; if (level !== 11'd0) begin errors++; $display("FAIL pop1_level got %0d want 0", level); end
  endtask

  task automatic test_two_word();
    doReset();
    op_valid = 1'b1; push_pop = 1'b1; op_two = 1'b1;
    #1;
    checks++; if (mem_addr !== 32'h000F_FFFF) begin errors++; $display("FAIL push2_w0_addr got %h want 000fffff", mem_addr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL push2_w0_busy got %0b want 0", busy); end
    tick();
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL push2_w1_busy got %0b want 1", busy); end
    checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL push2_w1_en got %0b want 1", mem_en); end
    checks++; if (mem_word !== 1'b1) begin errors++; $display("FAIL push2_w1_word got %0b want 1", mem_word); end
    checks++; if (mem_addr !== 32'h000F_FFFE) begin errors++; $display("FAIL push2_w1_addr got %h want 000ffffe", mem_addr); end
    checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL push2_w1_ready got %0b want 0", op_ready); end
    tick();
    push_pop = 1'b0;
    #1;
    checks++; if (sp !== 32'h000F_FFFD) begin errors++; $display("FAIL push2_sp got %h want 000ffffd", sp); end
    checks++; if (level !== 11'd2) begin errors++; $display("FAIL push2_level got %0d want 2", level); end
    checks++; if (mem_addr !== 32'h000F_FFFE) begin errors++; $display("FAIL pop2_w0_addr got %h want 000ffffe", mem_addr); end
    checks++; if (mem_word !== 1'b0) begin errors++; $display("FAIL pop2_w0_word got %0b want 0", mem_word); end
    tick();
    op_valid = 1'b0;
    #1;
    checks++; if (mem_addr !== 32'h000F_FFFF) begin errors++; $display("FAIL pop2_w1_addr got %h want 000fffff", mem_addr); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pop2_w1_busy got %0b want 1", busy); end
    tick();
    op_two = 1'b0;
    #1;
    checks++; if (sp !== 32'h000F_FFFF) begin errors++; $display("FAIL pop2_sp got %h want 000fffff", sp); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pop2_end_busy got %0b want 0", busy); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL pop2_end_en got %0b want 0", mem_en); end
  endtask

  task automatic test_underflow();
    doReset();
    op_valid = 1'b1; push_pop = 1'b0; op_two = 1'b0;
    #1;
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL uf_ready got %0b want 1", op_ready); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL uf_en got %0b want 0", mem_en); end
    tick();
    op_valid = 1'b0;
    #1;
    checks++; if (sp !== 32'h000F_FFFF) begin errors++; $display("FAIL uf_sp got %h want 000fffff", sp); end
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_flag got %0b want 1", underflow); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL uf_ovf got %0b want 0", overflow); end
    exc_clr = 1'b1;
    tick();
    exc_clr = 1'b0;
    #1;
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL uf_clr got %0b want 0", underflow); end
    op_valid = 1'b1; push_pop = 1'b1;
    tick();
    // Two-word pop with one word stacked, plus a simultaneous clear.
    push_pop = 1'b0; op_two = 1'b1; exc_clr = 1'b1;
    #1;
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL uf2_en got %0b want 0", mem_en); end
    tick();
    op_valid = 1'b0; op_two = 1'b0; exc_clr = 1'b0;
    #1;
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf2_set_wins got %0b want 1", underflow); end
    checks++; if (sp !== 32'h000F_FFFE) begin errors++; $display("FAIL uf2_sp got %h want 000ffffe", sp); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL uf2_busy got %0b want 0", busy); end
  endtask

  task automatic test_overflow();
    doReset();
    op_valid = 1'b1; push_pop = 1'b1; op_two = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    op_two = 1'b1;
    #1;
    checks++; if (sLevel !== 3'd3) begin errors++; $display("FAIL ovf_level3 got %0d want 3", sLevel); end
    checks++; if (sMemEn !== 1'b0) begin errors++; $display("FAIL ovf2_en got %0b want 0", sMemEn); end
    tick();
    op_valid = 1'b0; op_two = 1'b0;
    #1;
    checks++; if (sOverflow !== 1'b1) begin errors++; $display("FAIL ovf2_flag got %0b want 1", sOverflow); end
    checks++; if (sLevel !== 3'd3) begin errors++; $display("FAIL ovf2_level got %0d want 3", sLevel); end
    checks++; if (sBusy !== 1'b0) begin errors++; $display("FAIL ovf2_busy got %0b want 0", sBusy); end
    checks++; if (sSp !== 32'h000F_FFFC) begin errors++; $display("FAIL ovf2_sp got %h want 000ffffc", sSp); end
    op_valid = 1'b1;
    #1;
    checks++; if (sMemEn !== 1'b1) begin errors++; $display("FAIL last_push_en got %0b want 1", sMemEn); end
    checks++; if (sMemAddr !== 32'h000F_FFFC) begin errors++; $display("FAIL last_push_addr got %h want 000ffffc", sMemAddr); end
    tick();
    #1;
    checks++; if (sLevel !== 3'd4) begin errors++; $display("FAIL full_level got %0d want 4", sLevel); end
    checks++; if (sSp !== 32'h000F_FFFB) begin errors++; $display("FAIL full_sp got %h want 000ffffb", sSp); end
    checks++; if (sMemEn !== 1'b0) begin errors++; $display("FAIL full_push_en got %0b want 0", sMemEn); end
    tick();
    op_valid = 1'b0; exc_clr = 1'b1;
    tick();
    exc_clr = 1'b0;
    #1;
    checks++; if (sOverflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got %0b want 0", sOverflow); end
    checks++; if (sLevel !== 3'd4) begin errors++; $display("FAIL full_hold_level got %0d want 4", sLevel); end
  endtask

  task automatic test_sp_load();
    doReset();
    sp_load = 1'b1; sp_load_val = 32'h0000_0100; op_valid = 1'b1; push_pop = 1'b1;
    #1;
    checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL load_ready got %0b want 0", op_ready); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL load_en got %0b want 0", mem_en); end
    tick();
    sp_load = 1'b0; op_valid = 1'b0;
    #1;
    checks++; if (sp !== 32'h0000_0100) begin errors++; $display("FAIL load_sp got %h want 00000100", sp); end
    checks++; if (level !== 11'h6FF) begin errors++; $display("FAIL load_level got %h want 6ff", level); end
    op_valid = 1'b1; push_pop = 1'b0; op_two = 1'b1;
    #1;
    checks++; if (mem_addr !== 32'h0000_0101) begin errors++; $display("FAIL ldpop_w0_addr got %h want 00000101", mem_addr); end
    tick();
    op_valid = 1'b0; sp_load = 1'b1; sp_load_val = 32'h0000_0500;
    #1;
    checks++; if (mem_addr !== 32'h0000_0102) begin errors++; $display("FAIL ldpop_w1_addr got %h want 00000102", mem_addr); end
    tick();
    sp_load = 1'b0; op_two = 1'b0;
    #1;
    checks++; if (sp !== 32'h0000_0102) begin errors++; $display("FAIL load_in_second got %h want 00000102", sp); end
  endtask

  task automatic test_truncation();
    doReset();
    sp_load = 1'b1; sp_load_val = 32'hFFFF_FFFF;
    tick();
    sp_load = 1'b0; op_valid = 1'b1; push_pop = 1'b1; op_two = 1'b0;
    #1;
    checks++; if (level !== 11'd0) begin errors++; $display("FAIL trunc_level0 got %0d want 0", level); end
    checks++; if (mem_addr !== 32'hFFFF_FFFF) begin errors++; $display("FAIL trunc_addr got %h want ffffffff", mem_addr); end
    tick();
    op_valid = 1'b0;
    #1;
    checks++; if (sp !== 32'hFFFF_FFFE) begin errors++; $display("FAIL trunc_sp got %h want fffffffe", sp); end
    checks++; if (level !== 11'd1) begin errors++; $display("FAIL trunc_level1 got %0d want 1", level); end
  endtask

  task automatic test_reset_in_second();
    doReset();
    op_valid = 1'b1; push_pop = 1'b1; op_two = 1'b1;
    tick();
    reset = 1'b0; op_valid = 1'b0;
    #1;
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rst2_en got %0b want 0", mem_en); end
    checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL rst2_ready got %0b want 0", op_ready); end
    tick();
    reset = 1'b1; op_two = 1'b0;
    #1;
    checks++; if (sp !== 32'h000F_FFFF) begin errors++; $display("FAIL rst2_sp got %h want 000fffff", sp); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst2_busy got %0b want 0", busy); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rst2_after_en got %0b want 0", mem_en); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] expAddr;
    doReset();
    op_valid = 1'b1; push_pop = 1'b1; op_two = 1'b0;
    expAddr = 32'h000F_FFFF;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (mem_addr !== expAddr) begin errors++; $display("FAIL b2b_addr%0d got %h want %h", i, mem_addr, expAddr); end
      tick();
      expAddr = expAddr - 32'd1;
    end
    op_valid = 1'b0;
    #1;
    checks++; if (level !== 11'd3) begin errors++; $display("FAIL b2b_level got %0d want 3", level); end
  endtask

  initial begin
    test_reset();
    test_push_single();
    test_two_word();
    test_underflow();
    test_overflow();
    test_sp_load();
    test_truncation();
    test_reset_in_second();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 SHALL expose parameter ADDR_W, default 32, width of all stack addresses.
REQ-002 SHALL expose parameter SP_INIT, default 32'h000F_FFFF, the SP value for an empty stack, which is also the top word address.
REQ-003 SHALL expose parameter DEPTH, default 1024, the stack capacity in words, 1 <= DEPTH <= SP_INIT.
REQ-004 SHALL have a single clock and a synchronous, active-low reset; the ports are clk and reset.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 reset  in  1  synchronous, active-low; 0 at a rising clk edge resets the block.
REQ-007 op_valid  in  1  stack operation request.
REQ-008 push_pop  in  1  1 = push, 0 = pop; sampled with op_valid.
REQ-009 op_two  in  1  1 = two-word operation (CALL/RET/INT frame), 0 = single word.
REQ-010 op_ready  out  1  request accepted when op_valid && op_ready.
REQ-011 sp_load  in  1  load SP from sp_load_val.
REQ-012 sp_load_val  in  ADDR_W  new SP value.
REQ-013 exc_clr  in  1  clears sticky exception flags.
REQ-014 mem_en  out  1  stack memory access this cycle.
REQ-015 mem_addr  out  ADDR_W  stack word address for the current access.
REQ-016 mem_word  out  1  index of the word in the operation (0 first, 1 second).
REQ-017 busy  out  1  second word of a two-word operation is in progress.
REQ-018 sp  out  ADDR_W  current SP register, pointing at the first empty location.
REQ-019 level  out  $clog2(DEPTH+1)  words currently on the stack.
REQ-020 overflow  out  1  sticky: a push was rejected for lack of space.
REQ-021 underflow  out  1  sticky: a pop was rejected for lack of data.

Function
REQ-022 The stack SHALL grow downward; empty when sp == SP_INIT; full when level == DEPTH.
REQ-023 Level SHALL equal SP_INIT - sp, truncated to the width of level.
REQ-024 The FSM SHALL have two states. IDLE -> SECOND on acceptance of a valid two-word op. SECOND -> IDLE unconditionally after one cycle. Single-word ops stay in IDLE.
REQ-025 op_ready SHALL equal (state == IDLE) && !sp_load.
REQ-026 Push word access SHALL use mem_addr = sp (combinational), and sp SHALL be decremented by 1 at the same clock edge.
REQ-027 Pop word access SHALL use mem_addr = sp + 1 (combinational), and sp SHALL be incremented by 1 at the same clock edge.
REQ-028 On acceptance, mem_en = 1 and mem_word = 0 in the same cycle, i.e. zero latency.
REQ-029 In SECOND, mem_en = 1, mem_word = 1 and busy = 1, with the address per REQ-026/027 computed from the already-updated sp.
REQ-030 Net sp change SHALL be -2 for a two-word push and +2 for a two-word pop.
REQ-031 Capacity SHALL be checked on acceptance for the whole operation: push requires DEPTH - level >= n; pop requires level >= n, where n = 1 or 2.
REQ-032 A rejected op SHALL take no memory access (mem_en = 0), leave sp unchanged, cause no SECOND state, and set overflow (push) or underflow (pop) at the next edge.
REQ-033 A partial two-word op SHALL never occur.
REQ-034 sp_load SHALL set sp <= sp_load_val at the next edge, in IDLE only; it is ignored in SECOND.
REQ-035 sp_load SHALL block acceptance of any op that cycle; no range check is applied to sp_load_val.
REQ-036 If exc_clr and a new rejection occur in the same cycle, set SHALL win.
REQ-037 exc_clr SHALL otherwise clear both flags at the next edge.
REQ-038 Address arithmetic SHALL be modulo 2^ADDR_W, with no saturation.
REQ-039 Outside an accepted op or the SECOND state, mem_en SHALL be 0, and mem_addr SHALL show sp and mem_word 0.

Reset
REQ-040 On reset = 0 at a clk edge: sp <= SP_INIT, state <= IDLE, overflow <= 0, underflow <= 0.
REQ-041 Reset SHALL override op_valid, sp_load and exc_clr, and SHALL abort a SECOND state without issuing word 1.
REQ-042 During the reset cycle, mem_en SHALL be 0 and op_ready SHALL be 0.

Verification
REQ-043 Push single from reset -> mem_addr = 0x000F_FFFF with mem_en = 1; next cycle sp = 0x000F_FFFE and level = 1.
REQ-044 Two-word push then two-word pop from reset -> addresses FFFF then FFFE with busy = 1 on the second; pop addresses FFFF then FFFE? No: pop addresses 0x000F_FFFE then 0x000F_FFFF; sp ends at 0x000F_FFFF.
REQ-045 Pop on an empty stack -> mem_en = 0, sp unchanged, underflow = 1 the next cycle; exc_clr in the following cycle -> underflow = 0.
REQ-046 With DEPTH = 4: push x3, then two-word push -> rejected, overflow = 1, level stays 3; a single push is then accepted and level = 4.
REQ-047 sp_load = 1 with op_valid = 1, sp_load_val = 0x100 -> op_ready = 0, no access; sp = 0x100 the next cycle.
REQ-048 Reset = 0 asserted in SECOND of a two-word push -> no word-1 access; sp = SP_INIT and busy = 0 the next cycle.
